// File: rtl/cfg_lut_cell_if.sv
// Serial configuration port of a cfg_lut_cell: frame start/valid/data from the
// configuration controller, commit pulse and configured status back to it.
interface cfg_lut_cell_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_done;
  logic configured;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_bit,
    input  cfg_done,
    input  configured
  );

  modport slave (
    input  cfg_start,
    input  cfg_valid,
    input  cfg_bit,
    output cfg_done,
    output configured
  );
endinterface

// File: rtl/cfg_lut_cell.sv
// K-input LUT cell whose truth table and comb/registered mode are shifted in
// serially; a shadow register keeps the active configuration live during reloads.
module cfg_lut_cell #(
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] in,
  input  logic         ce,
  cfg_lut_cell_if.slave cfg,
  output logic         y
);
  localparam int NTAB  = 2 ** K;
  localparam int NBITS = NTAB + 1;
  localparam int CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {UNCFG, LOAD, READY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NTAB-1:0] shadow_q, shadow_d;
  logic [NTAB-1:0] lut_q, lut_d;
  logic            mode_q, mode_d;
  logic            flop_q, flop_d;
  logic            done_q, done_d;
  logic            configured_q, configured_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNCFG;
      cnt_q        <= '0;
      shadow_q     <= '0;
      lut_q        <= '0;
      mode_q       <= 1'b0;
      flop_q       <= 1'b0;
      done_q       <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      lut_q        <= lut_d;
      mode_q       <= mode_d;
      flop_q       <= flop_d;
      done_q       <= done_d;
      configured_q <= configured_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    lut_d        = lut_q;
    mode_d       = mode_q;
    done_d       = 1'b0;
    configured_d = configured_q;
    // The output flop tracks the active table regardless of mode or state.
    flop_d       = ce ? lut_q[in] : flop_q;

    case (state_q)
      UNCFG, READY: begin
        if (cfg.cfg_start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (cfg.cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg.cfg_valid) begin
          if (cnt_q == LAST) begin
            // Final bit is the mode; it goes straight to the active copy.
            lut_d        = shadow_q;
            mode_d       = cfg.cfg_bit;
            done_d       = 1'b1;
            configured_d = 1'b1;
            cnt_d        = '0;
            state_d      = READY;
          end else begin
            // LSB-first: after NTAB shifts, entry i sits at shadow bit i.
            shadow_d = {cfg.cfg_bit, shadow_q[NTAB-1:1]};
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  assign y              = configured_q & (mode_q ? flop_q : lut_q[in]);
  assign cfg.cfg_done   = done_q;
  assign cfg.configured = configured_q;
endmodule

// File: tb/tb_cfg_lut_cell.sv
// Randomized directed bench for cfg_lut_cell (K=2 and K=3) against a frame-level
// reference model that collects bits in a queue and commits whole frames.
module tb_cfg_lut_cell;
  localparam int NT2 = 4;
  localparam int NB2 = 5;
  localparam int NB3 = 9;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in2   = '0;
  logic       ce2   = 1'b0;
  logic       y2;
  logic [2:0] in3   = '0;
  logic       ce3   = 1'b0;
  logic       y3;

  cfg_lut_cell_if c2 ();
  cfg_lut_cell_if c3 ();

  cfg_lut_cell #(.K(2)) dut2 (.clk(clk), .rst_n(rst_n), .in(in2), .ce(ce2), .cfg(c2), .y(y2));
  cfg_lut_cell #(.K(3)) dut3 (.clk(clk), .rst_n(rst_n), .in(in3), .ce(ce3), .cfg(c3), .y(y3));

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int done_seen = 0;

  bit m_lut [NT2];
  bit m_mode, m_flop, m_cfgd, m_done, m_loading;
  bit m_frame [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_y(input logic [1:0] iv);
    if (!m_cfgd) return 1'b0;
    return m_mode ? m_flop : m_lut[iv];
  endfunction

  task automatic reset_model();
    foreach (m_lut[i]) m_lut[i] = 1'b0;
    m_mode = 0; m_flop = 0; m_cfgd = 0; m_done = 0; m_loading = 0;
    m_frame.delete();
  endtask

  // One clock cycle on the K=2 cell: drive, check comb y, clock, update model, check all.
  task automatic step2(input logic st, input logic vl, input logic bt,
                       input logic [1:0] iv, input logic cev, input string tag);
    c2.cfg_start = st; c2.cfg_valid = vl; c2.cfg_bit = bt; in2 = iv; ce2 = cev;
    #1;
    check({tag, "/y_pre"}, y2, model_y(iv));
    @(posedge clk);
    if (cev) m_flop = m_lut[iv];
    m_done = 0;
    if (st) begin
      m_frame.delete();
      m_loading = 1;
    end else if (vl && m_loading) begin
      m_frame.push_back(bt);
      if (m_frame.size() == NB2) begin
        for (int i = 0; i < NT2; i++) m_lut[i] = m_frame[i];
        m_mode    = m_frame[NT2];
        m_done    = 1;
        m_cfgd    = 1;
        m_loading = 0;
        m_frame.delete();
      end
    end
    #1;
    if (c2.cfg_done === 1'b1) done_seen++;
    check({tag, "/done"}, c2.cfg_done, m_done);
    check({tag, "/configured"}, c2.configured, m_cfgd);
    check({tag, "/y_post"}, y2, model_y(iv));
  endtask

  task automatic frame2(input logic [NB2-1:0] bits, input int gap_pct, input logic start_valid);
    step2(1'b1, start_valid, 1'($urandom), 2'($urandom), 1'($urandom), "start");
    for (int i = 0; i < NB2; i++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++)
        step2(1'b0, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), "gap");
      step2(1'b0, 1'b1, bits[i], 2'($urandom), 1'($urandom), "bit");
    end
  endtask

  task automatic idle2(input int n);
    for (int i = 0; i < n; i++)
      step2(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), "idle");
  endtask

  task automatic load3(input logic [NB3-1:0] bits);
    c3.cfg_start = 1'b1; c3.cfg_valid = 1'b0;
    @(posedge clk); #1;
    c3.cfg_start = 1'b0;
    for (int i = 0; i < NB3; i++) begin
      c3.cfg_valid = 1'b1; c3.cfg_bit = bits[i];
      @(posedge clk); #1;
      check("k3_done", c3.cfg_done, (i == NB3 - 1));
    end
    c3.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] or_seq;
    logic [3:0] or_exp;
    or_seq = 4'b0000;
    c2.cfg_start = 0; c2.cfg_valid = 0; c2.cfg_bit = 0;
    c3.cfg_start = 0; c3.cfg_valid = 0; c3.cfg_bit = 0;
    reset_model();

    #12;
    check("rst_y", y2, 1'b0);
    check("rst_configured", c2.configured, 1'b0);
    check("rst_done", c2.cfg_done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AND, combinational; y must stay 0 until commit
    done_seen = 0;
    frame2(5'b0_1000, 0, 1'b0);
    check("and_done_count", done_seen, 1);
    for (int v = 0; v < 4; v++) begin
      step2(1'b0, 1'b0, 1'b0, 2'(v), 1'($urandom), "and_sweep");
      check("and_tt", y2, (v == 3));
    end

    // Registered OR, then in = 0,2,0,3 with ce=1, then freeze with ce=0
    frame2(5'b1_1110, 0, 1'b0);
    step2(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, "or_prime");
    or_exp = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] iv;
      iv = (s == 1) ? 2'd2 : (s == 3) ? 2'd3 : 2'd0;
      step2(1'b0, 1'b0, 1'b0, iv, 1'b1, "or_seq");
      or_seq[s] = y2;
      check("or_lag", y2, or_exp[s]);
    end
    for (int s = 0; s < 4; s++) begin
      step2(1'b0, 1'b0, 1'b0, 2'($urandom), 1'b0, "or_freeze");
      check("or_frozen", y2, 1'b1);
    end

    // Select-driven AND/OR on the K=3 cell
    load3(9'b0_1000_1110);
    check("k3_configured", c3.configured, 1'b1);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] a;
      a = 3'(v);
      in3 = a;
      #1;
      check("k3_select", y3, a[2] ? (a[0] & a[1]) : (a[0] | a[1]));
    end

    // Hitless reload: AND active, OR frame with gaps in cfg_valid
    frame2(5'b0_1000, 0, 1'b0);
    frame2(5'b0_1110, 60, 1'b0);
    for (int v = 0; v < 4; v++) begin
      step2(1'b0, 1'b0, 1'b0, 2'(v), 1'($urandom), "or_sweep");
      check("or_tt", y2, (v != 0));
    end

    // Restart after 3 bits: only the second frame commits
    done_seen = 0;
    step2(1'b1, 1'b0, 1'b0, 2'($urandom), 1'($urandom), "rs_start");
    for (int i = 0; i < 3; i++)
      step2(1'b0, 1'b1, 1'b1, 2'($urandom), 1'($urandom), "rs_bit");
    frame2(5'b0_0110, 20, 1'b1);
    check("restart_done_count", done_seen, 1);
    for (int v = 0; v < 4; v++) begin
      step2(1'b0, 1'b0, 1'b0, 2'(v), 1'($urandom), "xor_sweep");
      check("xor_tt", y2, (v == 1 || v == 2));
    end

    // Random frames, gaps, start/valid collisions, stray valids outside LOAD
    for (int r = 0; r < 8; r++) begin
      frame2(5'($urandom), 30, 1'($urandom));
      idle2(6);
    end

    // Asynchronous reset two bits into a frame
    step2(1'b1, 1'b0, 1'b0, 2'($urandom), 1'($urandom), "mid_start");
    step2(1'b0, 1'b1, 1'b1, 2'($urandom), 1'($urandom), "mid_bit");
    step2(1'b0, 1'b1, 1'b0, 2'($urandom), 1'($urandom), "mid_bit");
    c2.cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check("arst_y", y2, 1'b0);
    check("arst_configured", c2.configured, 1'b0);
    check("arst_done", c2.cfg_done, 1'b0);
    check("arst_k3_configured", c3.configured, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NB2 + 2; i++)
      step2(1'b0, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom), "post_rst_valid");
    check("post_rst_unconfigured", c2.configured, 1'b0);
    frame2(5'b1_1000, 20, 1'b0);
    idle2(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_lut_cell.md
# cfg_lut_cell

Parametrised configurable logic cell: a K-input lookup table whose truth table and output mode (combinational or registered) are loaded serially at run time. It generalises the fixed AND/OR gates and the select-driven AND-or-OR gate pair into one programmable element. It is the basic tile of the team's teaching-FPGA fabric, where a configuration controller drives a chain of these cells.

## Interface
- K, default 2: number of LUT inputs, legal range 1..6; truth table is 2**K bits.
- NBITS (localparam) = 2**K + 1: configuration frame length, truth table plus the mode bit.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  K  LUT address inputs; in[0] is the LSB of the table index.
- ce  in  1  clock enable for the output flop in registered mode.
- cfg_start  in  1  one-cycle pulse that begins a new configuration frame.
- cfg_valid  in  1  qualifies cfg_bit; one bit is accepted per cycle with cfg_valid=1.
- cfg_bit  in  1  serial configuration data.
- cfg_done  out  1  one-cycle pulse when a frame commits.
- configured  out  1  high once at least one frame has committed since reset.
- y  out  1  cell output.

## Operation
- State machine with three states.
  - UNCFG (reset state): y=0, configured=0.
  - LOAD: accepting frame bits.
  - READY: active configuration drives y.
- Transitions:
  - UNCFG or READY to LOAD on cfg_start. The bit counter clears and the shadow register is discarded.
  - LOAD to READY on acceptance of bit NBITS-1. This commits the frame.
  - cfg_start while in LOAD restarts the frame: counter returns to 0 and already-received bits are discarded.
  - If cfg_start and cfg_valid are both high in the same cycle, cfg_start wins. That cfg_bit is not accepted.
  - cfg_valid outside LOAD is ignored.
- Frame order: bits are taken LSB-first.
  - Bits 0..2**K-1 are truth-table entries 0..2**K-1.
  - The final bit is the mode: 0 = combinational, 1 = registered.
- Shadowing:
  - Bits accumulate in a shadow register and counter of width clog2(NBITS+1).
  - The active table and mode update atomically on commit.
  - During a reload (LOAD entered from READY), the previous active configuration keeps driving y and configured stays 1.
  - A LOAD entered from UNCFG keeps y=0 until commit.
- Output:
  - Combinational mode: y = table[in], updating with no clock.
  - Registered mode: the flop samples table[in] on each clock edge with ce=1, holds when ce=0, and y = flop.
  - The flop updates from the active configuration in every state, including LOAD. The mode selects only what drives y.
  - The flop is reset to 0. A mode change does not clear it.
- Reset (asynchronous, any state, including mid-frame):
  - State returns to UNCFG.
  - Counter, shadow, active table, mode and flop all go to 0.
  - Outputs: y=0, cfg_done=0, configured=0.

## Timing
- Commit occurs on the clock edge that accepts the last bit.
- cfg_done is high for exactly the following cycle. configured rises in that same cycle and stays high until reset.
- Combinational mode: y reflects the new table in the cycle after that commit edge, and follows `in` with zero cycles of latency.
- Registered mode: y = table[in] sampled at the previous edge with ce=1, giving one cycle of latency.
  - On the first edge after commit, the flop samples using the new table.
- Minimum frame time is NBITS cycles after the cfg_start cycle. cfg_valid gaps simply extend the frame.
- No back-pressure: the cell accepts a bit on every valid cycle.

## Test plan
- **Reset then AND (K=2).** Stimulus: cfg_start, then frame 0,0,0,1 plus mode 0. Required: cfg_done pulses once, 1 cycle after the 5th bit. y=1 only for in=3. Before commit, y=0 for every input.
- **Registered OR (K=2).** Stimulus: frame 0,1,1,1 plus mode 1, ce=1, then in sequence 0,2,0,3. Required: y sequence lags by one cycle (0,0,1,0,1). Holding ce=0 freezes y.
- **Select-driven AND/OR (K=3, in[2] as select).** Stimulus: table 0,1,1,1,0,0,0,1 (entries 0..7), mode 0. Required: all 8 input combinations match `in[2] ? in[0]&in[1] : in[0]|in[1]`.
- **Hitless reload.** Stimulus: with AND active, start an OR frame and supply it with gaps in cfg_valid. Required: y stays AND-like through the last bit, becomes OR-like in the cycle after commit, and configured stays 1 throughout.
- **Restart and reset mid-frame.**
  - Stimulus: cfg_start after 3 bits, then a full frame. Required: only the second frame takes effect, and cfg_done pulses once.
  - Stimulus: drop rst_n after 2 bits. Required: y=0, configured=0 and cfg_done=0 immediately; subsequent cfg_valid is ignored until cfg_start.
